// File: rtl/c432_key_loader_if.sv
// Key-provisioning bus between a key source and c432_key_loader.
// The master drives the serial frame. The slave returns the committed key and status.
interface c432_key_loader_if #(
    parameter int unsigned KEY_W = 22
);
    logic             key_start;
    logic             key_valid;
    logic             key_bit;
    logic             key_ready;
    logic [3:0]       key_p;
    logic [KEY_W-5:0] key_x;
    logic             key_done;
    logic             key_err;
    logic             key_loaded;

    modport master (
        output key_start,
        output key_valid,
        output key_bit,
        input  key_ready,
        input  key_p,
        input  key_x,
        input  key_done,
        input  key_err,
        input  key_loaded
    );

    modport slave (
        input  key_start,
        input  key_valid,
        input  key_bit,
        output key_ready,
        output key_p,
        output key_x,
        output key_done,
        output key_err,
        output key_loaded
    );
endinterface

// File: rtl/c432_key_loader.sv
// Serial key loader for the locked c432 netlist.
// A frame is KEY_W key bits (LSB first) followed by one even-parity bit.
// The frame is collected in a shadow register and committed to key_p/key_x only
// when parity checks out, so the key outputs never show a partial frame.
module c432_key_loader #(
    parameter int unsigned KEY_W = 22,
    parameter int unsigned CNT_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    c432_key_loader_if.slave    bus
);

    typedef enum logic [1:0] {StIdle, StLoad, StCheck} state_e;

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [KEY_W-1:0] r_shadow;
    logic             r_par;
    logic             r_ready;
    logic [3:0]       r_key_p;
    logic [KEY_W-5:0] r_key_x;
    logic             r_done;
    logic             r_err;
    logic             r_loaded;

    logic             w_accept;
    logic             w_last;

    assign w_accept = bus.key_valid & r_ready;
    // Counter reaching KEY_W means the next accepted bit is the parity bit
    assign w_last   = (r_cnt == CNT_W'(KEY_W));

    // Frame FSM with registered outputs: collect, check parity, commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_par    <= 1'b0;
            r_ready  <= 1'b0;
            r_key_p  <= '0;
            r_key_x  <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_loaded <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.key_start) begin
                        r_state  <= StLoad;
                        r_ready  <= 1'b1;
                        r_cnt    <= '0;
                        r_shadow <= '0;
                        r_par    <= 1'b0;
                        r_err    <= 1'b0;
                    end
                end
                StLoad: begin
                    if (bus.key_start) begin
                        // Abort and restart; a bit offered in this cycle is dropped
                        r_cnt    <= '0;
                        r_shadow <= '0;
                        r_par    <= 1'b0;
                        r_err    <= 1'b0;
                    end else if (w_accept) begin
                        r_par <= r_par ^ bus.key_bit;
                        if (w_last) begin
                            r_state <= StCheck;
                            r_ready <= 1'b0;
                        end else begin
                            r_shadow[r_cnt] <= bus.key_bit;
                            r_cnt           <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                StCheck: begin
                    // key_start is deliberately ignored here
                    r_state <= StIdle;
                    if (!r_par) begin
                        r_key_p  <= r_shadow[3:0];
                        r_key_x  <= r_shadow[KEY_W-1:4];
                        r_done   <= 1'b1;
                        r_loaded <= 1'b1;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.key_ready  = r_ready;
    assign bus.key_p      = r_key_p;
    assign bus.key_x      = r_key_x;
    assign bus.key_done   = r_done;
    assign bus.key_err    = r_err;
    assign bus.key_loaded = r_loaded;

endmodule

// File: tb/tb_c432_key_loader.sv
// Self-checking bench for c432_key_loader: directed frames plus randomized
// frames compared against a frame-level reference model.
module tb_c432_key_loader;

    localparam int unsigned KEY_W = 22;

    logic clk;
    logic rst_n;

    c432_key_loader_if #(.KEY_W(KEY_W)) bus ();

    c432_key_loader #(.KEY_W(KEY_W), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the committed key and flags should be
    logic [3:0]  exp_p;
    logic [17:0] exp_x;
    logic        exp_err;
    logic        exp_loaded;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_p      = '0;
        exp_x      = '0;
        exp_err    = 1'b0;
        exp_loaded = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_p"},      {28'd0, bus.key_p},        {28'd0, exp_p});
        check({tag, "_x"},      {14'd0, bus.key_x},        {14'd0, exp_x});
        check({tag, "_err"},    {31'd0, bus.key_err},      {31'd0, exp_err});
        check({tag, "_loaded"}, {31'd0, bus.key_loaded},   {31'd0, exp_loaded});
    endtask

    // Drive one frame starting at a negedge; returns at the negedge of the cycle
    // where key_done is expected. gap: 0 none, >0 fixed idle cycles, <0 random.
    task automatic do_frame(input logic [21:0] frame, input logic pbit, input int gap,
                            input int abort_after, input bit start_in_check);
        logic good;
        int   ng;
        good = ((^frame) ^ pbit) == 1'b0;

        bus.key_start = 1'b1;
        bus.key_valid = 1'b0;
        @(negedge clk);
        bus.key_start = 1'b0;
        check("ready_after_start", {31'd0, bus.key_ready}, 32'd1);
        check("done_one_cycle",    {31'd0, bus.key_done},  32'd0);
        check("err_clr_on_start",  {31'd0, bus.key_err},   32'd0);
        exp_err = 1'b0;

        if (abort_after > 0) begin
            for (int k = 0; k < abort_after; k++) begin
                bus.key_valid = 1'b1;
                bus.key_bit   = 1'b1;
                @(negedge clk);
            end
            bus.key_start = 1'b1;
            bus.key_valid = 1'b1;
            bus.key_bit   = 1'b1;
            @(negedge clk);
            bus.key_start = 1'b0;
            bus.key_valid = 1'b0;
            check("ready_after_abort", {31'd0, bus.key_ready}, 32'd1);
        end

        for (int i = 0; i <= KEY_W; i++) begin
            if (gap != 0 && i > 0) begin
                ng = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                repeat (ng) begin
                    bus.key_valid = 1'b0;
                    bus.key_bit   = 1'($urandom);
                    @(negedge clk);
                end
            end
            if (i == 11) begin
                check("no_partial_done", {31'd0, bus.key_done}, 32'd0);
                check_outputs("no_partial");
            end
            bus.key_valid = 1'b1;
            bus.key_bit   = (i < KEY_W) ? frame[i] : pbit;
            @(negedge clk);
        end
        bus.key_valid = 1'b0;

        // Cycle n+1: CHECK
        check("check_ready_low", {31'd0, bus.key_ready}, 32'd0);
        check("check_no_done",   {31'd0, bus.key_done},  32'd0);
        if (start_in_check) bus.key_start = 1'b1;
        @(negedge clk);
        bus.key_start = 1'b0;

        // Cycle n+2: result visible
        if (good) begin
            exp_p      = frame[3:0];
            exp_x      = frame[21:4];
            exp_loaded = 1'b1;
        end else begin
            exp_err = 1'b1;
        end
        check("done_pulse", {31'd0, bus.key_done}, {31'd0, good});
        check("idle_ready", {31'd0, bus.key_ready}, 32'd0);
        check_outputs("commit");
    endtask

    initial begin
        logic [21:0] fr;
        logic        bad;
        int          gsel;
        int          ab;
        bit          sic;

        rst_n         = 1'b1;
        bus.key_start = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_bit   = 1'b0;
        model_reset();

        // Asynchronous reset between clock edges
        #7 rst_n = 1'b0;
        #1;
        check("rst_ready",  {31'd0, bus.key_ready}, 32'd0);
        check("rst_done",   {31'd0, bus.key_done},  32'd0);
        check_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            bus.key_valid = 1'b1;
            @(negedge clk);
            check("idle_ready_low", {31'd0, bus.key_ready}, 32'd0);
        end
        bus.key_valid = 1'b0;

        // Good frame: 0x2A5A5A has eleven ones, so even parity needs a 1
        fr = 22'h2A5A5A;
        do_frame(fr, ^fr, 0, 0, 1'b0);

        // Bad parity after a good key: committed key must survive
        do_frame(22'h000001, 1'b0, 0, 0, 1'b0);

        // Gapped input, valid pattern 1,0,0,1,...
        fr = 22'h2A5A5A;
        do_frame(fr, ^fr, 2, 0, 1'b0);

        // Abort after 10 ones, then a clean frame
        do_frame(22'h000005, 1'b0, 0, 10, 1'b0);

        // key_start during CHECK is ignored
        fr = 22'h15A3C7;
        do_frame(fr, ^fr, 0, 0, 1'b1);
        @(negedge clk);
        check("start_in_check_ignored", {31'd0, bus.key_ready}, 32'd0);

        // Reset mid-frame wipes the committed key
        bus.key_start = 1'b1;
        @(negedge clk);
        bus.key_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.key_valid = 1'b1;
            bus.key_bit   = 1'($urandom);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        bus.key_valid = 1'b0;
        #1;
        model_reset();
        check_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle", {31'd0, bus.key_ready}, 32'd0);

        // Randomized frames, mostly back-to-back (start in the key_done cycle)
        for (int n = 0; n < 30; n++) begin
            fr   = 22'($urandom);
            bad  = ($urandom_range(0, 3) == 0);
            gsel = int'($urandom_range(0, 3));
            ab   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 21)) : 0;
            sic  = ($urandom_range(0, 3) == 0);
            do_frame(fr, (^fr) ^ bad, (gsel == 3) ? -1 : gsel, ab, sic);
            if (sic) @(negedge clk);
        end

        @(negedge clk);
        check("final_done_low", {31'd0, bus.key_done}, 32'd0);
        check_outputs("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
